// File: rtl/selecting_result_judge.sv
// Judges a slot-machine reel result once every reel has stopped and the code has been stable
// for SETTLE cycles, then presents the score and a blink pattern on wins.
module selecting_result_judge #(
  parameter int unsigned SETTLE    = 16,
  parameter int unsigned BLINK_DIV = 12500000,
  parameter int unsigned BLINK_N   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  flag,
  input  logic [27:0] code,
  output logic        result_valid,
  output logic        win,
  output logic [7:0]  score_bcd,
  output logic        blink
);

  localparam int unsigned SetW = $clog2(SETTLE + 1);
  localparam int unsigned DivW = $clog2(BLINK_DIV + 1);
  localparam int unsigned TogW = $clog2(BLINK_N + 1);

  typedef enum logic [2:0] {StIdle, StSettle, StEval, StShow, StHold} state_e;

  // Declaration initialisers give reset values in simulation before rst is ever asserted.
  state_e            state_q   = StIdle;
  state_e            state_d;
  logic [27:0]       code_q    = '0;
  logic [27:0]       code_d;
  logic [SetW-1:0]   set_cnt_q = '0;
  logic [SetW-1:0]   set_cnt_d;
  logic [DivW-1:0]   div_q     = '0;
  logic [DivW-1:0]   div_d;
  logic [TogW-1:0]   tog_q     = '0;
  logic [TogW-1:0]   tog_d;
  logic              valid_q   = 1'b0;
  logic              valid_d;
  logic              win_q     = 1'b0;
  logic              win_d;
  logic [7:0]        score_q   = '0;
  logic [7:0]        score_d;
  logic              blink_q   = 1'b0;
  logic              blink_d;

  logic              any_run;
  logic              div_wrap;
  logic              last_tog;
  logic [7:0]        judged;

  // Score of a latched code as two BCD digits; out-of-range fields compare as raw nibbles.
  function automatic logic [7:0] judge(input logic [27:0] c);
    logic [2:0] m;
    logic [6:0] s;
    logic [6:0] tens;
    logic [6:0] ones;
    m = '0;
    for (int i = 0; i < 5; i++) begin
      if (c[4*i +: 4] == c[3:0]) m = m + 3'd1;
    end
    case (m)
      3'd5:    s = 7'd50;
      3'd4:    s = 7'd20;
      3'd3:    s = 7'd10;
      3'd2:    s = 7'd2;
      default: s = 7'd0;
    endcase
    if (c[27:24] == 4'd4 && c[23:20] == 4'hA) s = s + 7'd30;
    if (s > 7'd99) s = 7'd99;
    tens = s / 7'd10;
    ones = s % 7'd10;
    return {tens[3:0], ones[3:0]};
  endfunction

  assign any_run  = (flag != 7'h00);
  assign div_wrap = (div_q == DivW'(BLINK_DIV - 1));
  assign last_tog = div_wrap && (tog_q == TogW'(BLINK_N - 1));
  assign judged   = judge(code_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      code_q    <= '0;
      set_cnt_q <= '0;
      div_q     <= '0;
      tog_q     <= '0;
      valid_q   <= 1'b0;
      win_q     <= 1'b0;
      score_q   <= '0;
      blink_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      set_cnt_q <= set_cnt_d;
      div_q     <= div_d;
      tog_q     <= tog_d;
      valid_q   <= valid_d;
      win_q     <= win_d;
      score_q   <= score_d;
      blink_q   <= blink_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    set_cnt_d = set_cnt_q;
    div_d     = div_q;
    tog_d     = tog_q;
    valid_d   = valid_q;
    win_d     = win_q;
    score_d   = score_q;
    blink_d   = blink_q;
    unique case (state_q)
      StIdle: begin
        if (!any_run) begin
          state_d   = StSettle;
          code_d    = code;
          set_cnt_d = '0;
        end
      end
      StSettle: begin
        if (any_run) begin
          state_d = StIdle;
        end else if (code != code_q) begin
          code_d    = code;
          set_cnt_d = '0;
        end else begin
          set_cnt_d = set_cnt_q + SetW'(1);
          if (set_cnt_q == SetW'(SETTLE - 1)) state_d = StEval;
        end
      end
      StEval: begin
        state_d = StShow;
        score_d = judged;
        win_d   = (judged != 8'h00);
        valid_d = 1'b1;
        blink_d = 1'b0;
        div_d   = '0;
        tog_d   = '0;
      end
      StShow: begin
        if (any_run) begin
          state_d = StIdle;
          valid_d = 1'b0;
          win_d   = 1'b0;
          score_d = '0;
          blink_d = 1'b0;
        end else if (!win_q) begin
          state_d = StHold;
          blink_d = 1'b0;
        end else if (div_wrap) begin
          div_d = '0;
          tog_d = tog_q + TogW'(1);
          if (last_tog) begin
            state_d = StHold;
            blink_d = 1'b0;
          end else begin
            blink_d = ~blink_q;
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StHold: begin
        if (any_run) begin
          state_d = StIdle;
          valid_d = 1'b0;
          win_d   = 1'b0;
          score_d = '0;
          blink_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    result_valid = valid_q;
    win          = win_q;
    score_bcd    = score_q;
    blink        = blink_q;
  end

endmodule

// File: tb/tb_selecting_result_judge.sv
// Randomised and directed bench for selecting_result_judge against a behavioural game model.
module tb_selecting_result_judge;

  localparam int unsigned SETTLE    = 4;
  localparam int unsigned BLINK_DIV = 3;
  localparam int unsigned BLINK_N   = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  flag = 7'h7F;
  logic [27:0] code = '0;
  logic        result_valid;
  logic        win;
  logic [7:0]  score_bcd;
  logic        blink;

  int total = 0;
  int bad   = 0;

  selecting_result_judge #(
    .SETTLE    (SETTLE),
    .BLINK_DIV (BLINK_DIV),
    .BLINK_N   (BLINK_N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flag         (flag),
    .code         (code),
    .result_valid (result_valid),
    .win          (win),
    .score_bcd    (score_bcd),
    .blink        (blink)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Game rules: matches of digit0 among the five digits set the base, char 4 + letter A adds 30.
  function automatic logic [7:0] model_score(input logic [27:0] c);
    int m;
    int s;
    int base[6] = '{0, 0, 2, 10, 20, 50};
    m = 0;
    for (int i = 0; i < 5; i++) begin
      if (((c >> (4 * i)) & 28'hF) == (c & 28'hF)) m++;
    end
    s = base[m];
    if (((c >> 24) & 28'hF) == 28'd4 && ((c >> 20) & 28'hF) == 28'hA) s += 30;
    if (s > 99) s = 99;
    return 8'((s / 10) * 16 + (s % 10));
  endfunction

  // Model: phase 0 waiting for stop, 1 settling, 2 judging, 3 showing, 4 holding.
  int          m_phase = 0;
  int          m_run   = 0;
  int          m_age   = 0;
  logic [27:0] m_code  = '0;
  logic        m_valid = 1'b0;
  logic        m_win   = 1'b0;
  logic [7:0]  m_score = '0;

  function automatic logic model_blink();
    if (m_phase == 3 && m_win) return 1'(((m_age / BLINK_DIV) % 2));
    return 1'b0;
  endfunction

  initial begin
    logic [6:0]  f;
    logic [27:0] c;
    forever begin
      @(posedge clk);
      f = flag;
      c = code;
      if (rst) begin
        m_phase = 0; m_run = 0; m_age = 0; m_code = '0;
        m_valid = 1'b0; m_win = 1'b0; m_score = '0;
      end else begin
        case (m_phase)
          0: if (f == 7'h00) begin m_phase = 1; m_code = c; m_run = 0; end
          1: begin
            if (f != 7'h00) m_phase = 0;
            else if (c != m_code) begin m_code = c; m_run = 0; end
            else begin
              m_run++;
              if (m_run == SETTLE) m_phase = 2;
            end
          end
          2: begin
            m_score = model_score(m_code);
            m_win   = (m_score != 8'h00);
            m_valid = 1'b1;
            m_age   = 0;
            m_phase = 3;
          end
          default: begin
            if (f != 7'h00) begin
              m_phase = 0; m_valid = 1'b0; m_win = 1'b0; m_score = '0;
            end else if (m_phase == 3) begin
              if (!m_win) m_phase = 4;
              else begin
                m_age++;
                if (m_age >= BLINK_DIV * BLINK_N) m_phase = 4;
              end
            end
          end
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("model_cycle", {21'd0, result_valid, win, score_bcd, blink},
          {21'd0, m_valid, m_win, m_score, model_blink()});
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [27:0] rand_code();
    logic [3:0]  d0;
    logic [19:0] dg;
    logic [3:0]  ch;
    logic [3:0]  le;
    d0 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
    dg = {16'h0, d0};
    for (int i = 1; i < 5; i++) begin
      dg[4*i +: 4] = ($urandom_range(0, 1) == 1) ? d0 : 4'($urandom_range(0, 15));
    end
    ch = ($urandom_range(0, 1) == 1) ? 4'd4 : 4'($urandom_range(0, 15));
    le = ($urandom_range(0, 1) == 1) ? 4'hA : 4'($urandom_range(0, 15));
    return {ch, le, dg};
  endfunction

  initial begin
    int toggles;
    logic prev_blink;
    logic saw;
    #1;
    chk("pre_reset_outputs", {22'd0, result_valid, win, score_bcd}, 32'd0);
    chk("pre_reset_blink", {31'd0, blink}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    chk("reset_outputs", {21'd0, result_valid, win, score_bcd, blink}, 32'd0);
    cyc();

    // Jackpot: 4A / 77777.
    flag = 7'h00;
    code = 28'h4A_77777;
    for (int k = 1; k <= SETTLE + 2; k++) begin
      cyc();
      if (k == SETTLE + 1) chk("jackpot_not_early", {31'd0, result_valid}, 32'd0);
    end
    chk("jackpot_valid", {31'd0, result_valid}, 32'd1);
    chk("jackpot_win", {31'd0, win}, 32'd1);
    chk("jackpot_score", {24'd0, score_bcd}, 32'h80);
    chk("jackpot_model_score", {24'd0, m_score}, 32'h80);
    chk("jackpot_blink0", {31'd0, blink}, 32'd0);
    toggles = 0;
    prev_blink = blink;
    for (int j = 1; j <= BLINK_DIV * BLINK_N; j++) begin
      cyc();
      if (blink != prev_blink) toggles++;
      prev_blink = blink;
      if (j == BLINK_DIV) chk("jackpot_first_toggle", {31'd0, blink}, 32'd1);
    end
    chk("jackpot_toggles", toggles, 32'd6);
    chk("jackpot_blink_end", {31'd0, blink}, 32'd0);
    repeat (5) cyc();
    chk("jackpot_hold", {21'd0, result_valid, win, score_bcd, blink}, {21'd0, 1'b1, 1'b1, 8'h80, 1'b0});

    // No match.
    flag = 7'h7F;
    cyc();
    chk("new_game_clear", {31'd0, result_valid}, 32'd0);
    flag = 7'h00;
    code = 28'h0B_12345;
    saw = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (blink) saw = 1'b1;
    end
    chk("nomatch_out", {22'd0, result_valid, win, score_bcd}, {22'd0, 1'b1, 1'b0, 8'h00});
    chk("nomatch_blink_never", {31'd0, saw}, 32'd0);

    // Unstable code during settle: result must use the later code and restart the window.
    flag = 7'h7F;
    cyc();
    flag = 7'h00;
    code = 28'h1C_55555;
    cyc(); cyc();
    code = 28'h2D_11211;
    for (int k = 1; k <= SETTLE + 2; k++) begin
      cyc();
      if (k == SETTLE + 1) chk("unstable_not_early", {31'd0, result_valid}, 32'd0);
    end
    chk("unstable_score", {23'd0, result_valid, score_bcd}, {23'd0, 1'b1, 8'h20});
    repeat (22) cyc();

    // Reset while holding score 20, then a fresh judgement.
    chk("hold_before_reset", {24'd0, score_bcd}, 32'h20);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("reset_in_hold", {21'd0, result_valid, win, score_bcd, blink}, 32'd0);
    for (int k = 1; k <= SETTLE + 2; k++) begin
      cyc();
      if (k == SETTLE + 1) chk("post_reset_not_early", {31'd0, result_valid}, 32'd0);
    end
    chk("post_reset_judge", {23'd0, result_valid, score_bcd}, {23'd0, 1'b1, 8'h20});
    repeat (22) cyc();

    // Premature restart during settle.
    flag = 7'h7F;
    cyc();
    flag = 7'h00;
    code = 28'h4A_77777;
    cyc(); cyc();
    flag = 7'h08;
    cyc();
    flag = 7'h7F;
    saw = 1'b0;
    for (int k = 0; k < 15; k++) begin
      cyc();
      if (result_valid) saw = 1'b1;
    end
    chk("restart_no_valid", {31'd0, saw}, 32'd0);

    // Abort mid-blink.
    flag = 7'h00;
    for (int k = 0; k < SETTLE + 2 + 4; k++) cyc();
    chk("abort_blinking", {31'd0, blink}, 32'd1);
    flag = 7'h01;
    cyc();
    chk("abort_clear", {21'd0, result_valid, win, score_bcd, blink}, 32'd0);

    // Random play.
    for (int k = 0; k < 3000; k++) begin
      if (flag != 7'h00) flag = ($urandom_range(0, 1) == 1) ? 7'h00 : 7'($urandom);
      else if ($urandom_range(0, 39) == 0) flag = 7'($urandom_range(1, 127));
      if ($urandom_range(0, 29) == 0) code = rand_code();
      rst = ($urandom_range(0, 499) == 0);
      cyc();
    end
    rst = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
